// File: rtl/mem_write_arbiter.sv
// Two-source write-request merger: per-source FIFOs feeding a round-robin arbiter
// and a registered valid/ready output stage toward the memory controller.
module mem_write_arbiter #(
  parameter int ADDR_W = 27,
  parameter int DATA_W = 128,
  parameter int MASK_W = 16,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     fb_w_valid,
  input  logic [ADDR_W-1:0]        fb_w_addr,
  input  logic [DATA_W-1:0]        fb_w_data,
  input  logic [MASK_W-1:0]        fb_w_mask,
  output logic                     fb_w_ready,
  input  logic                     bvh_w_valid,
  input  logic [ADDR_W-1:0]        bvh_w_addr,
  input  logic [DATA_W-1:0]        bvh_w_data,
  input  logic [MASK_W-1:0]        bvh_w_mask,
  output logic                     bvh_w_ready,
  output logic                     out_w_valid,
  output logic [ADDR_W-1:0]        out_w_addr,
  output logic [DATA_W-1:0]        out_w_data,
  output logic [MASK_W-1:0]        out_w_mask,
  output logic                     out_w_src,
  input  logic                     out_w_ready,
  output logic [$clog2(DEPTH):0]   fb_level,
  output logic [$clog2(DEPTH):0]   bvh_level,
  output logic [15:0]              drop_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int EW = ADDR_W + DATA_W + MASK_W;

  logic [1:0]    in_valid;
  logic [1:0]    in_ready;
  logic [1:0]    push;
  logic [1:0]    pop;
  logic [1:0]    not_empty;
  logic [EW-1:0] in_entry [2];
  logic [EW-1:0] head [2];
  logic [LW-1:0] level [2];

  logic          load;
  logic          grant;
  logic          rr_reg;
  logic          rr_next;
  logic [1:0]    drops;
  logic [16:0]   drop_sum;

  // Index 0 is the frame-buffer source, index 1 the BVH source.
  assign in_valid    = {bvh_w_valid, fb_w_valid};
  assign in_entry[0] = {fb_w_addr, fb_w_data, fb_w_mask};
  assign in_entry[1] = {bvh_w_addr, bvh_w_data, bvh_w_mask};
  assign fb_w_ready  = in_ready[0];
  assign bvh_w_ready = in_ready[1];
  assign fb_level    = level[0];
  assign bvh_level   = level[1];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fifo
      logic [EW-1:0] mem [DEPTH];
      logic [PW-1:0] wr_ptr_reg;
      logic [PW-1:0] rd_ptr_reg;
      logic [LW-1:0] level_reg;

      // Room is judged on the registered level only; a same-cycle pop never frees a slot.
      assign in_ready[gi]  = (level_reg != LW'(DEPTH));
      assign push[gi]      = in_valid[gi] && in_ready[gi];
      assign not_empty[gi] = (level_reg != '0);
      assign head[gi]      = mem[rd_ptr_reg];
      assign level[gi]     = level_reg;

      always_ff @(posedge clk) begin
        if (push[gi]) mem[wr_ptr_reg] <= in_entry[gi];
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          level_reg  <= '0;
        end else begin
          if (push[gi]) wr_ptr_reg <= wr_ptr_reg + PW'(1);
          if (pop[gi])  rd_ptr_reg <= rd_ptr_reg + PW'(1);
          level_reg <= level_reg + LW'(push[gi]) - LW'(pop[gi]);
        end
      end
    end
  endgenerate

  // The round-robin pointer only advances when both sources actually compete.
  always_comb begin
    load    = !out_w_valid || out_w_ready;
    pop     = '0;
    rr_next = rr_reg;
    if (not_empty == 2'b11) begin
      grant = rr_reg;
    end else begin
      grant = not_empty[1];
    end
    if (load && (not_empty != 2'b00)) begin
      pop[grant] = 1'b1;
      if (not_empty == 2'b11) rr_next = ~rr_reg;
    end
  end

  assign drops    = 2'(in_valid[0] && !in_ready[0]) + 2'(in_valid[1] && !in_ready[1]);
  assign drop_sum = 17'(drop_count) + 17'(drops);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_w_valid <= 1'b0;
      out_w_addr  <= '0;
      out_w_data  <= '0;
      out_w_mask  <= '0;
      out_w_src   <= 1'b0;
      rr_reg      <= 1'b0;
      drop_count  <= '0;
    end else begin
      if (load) begin
        out_w_valid <= |not_empty;
        if (|not_empty) begin
          {out_w_addr, out_w_data, out_w_mask} <= head[grant];
          out_w_src <= grant;
        end
        rr_reg <= rr_next;
      end
      drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

endmodule

// File: tb/tb_mem_write_arbiter.sv
// Randomized bench for mem_write_arbiter: a queue-based reference model predicts every
// output, level, ready and drop count after each clock edge.
module tb_mem_write_arbiter;

  localparam int ADDR_W = 27;
  localparam int DATA_W = 128;
  localparam int MASK_W = 16;
  localparam int DEPTH  = 8;
  localparam int LW     = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [MASK_W-1:0] mask;
  } ent_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              fb_w_valid, bvh_w_valid;
  logic [ADDR_W-1:0] fb_w_addr, bvh_w_addr;
  logic [DATA_W-1:0] fb_w_data, bvh_w_data;
  logic [MASK_W-1:0] fb_w_mask, bvh_w_mask;
  logic              fb_w_ready, bvh_w_ready;
  logic              out_w_valid, out_w_src, out_w_ready;
  logic [ADDR_W-1:0] out_w_addr;
  logic [DATA_W-1:0] out_w_data;
  logic [MASK_W-1:0] out_w_mask;
  logic [LW-1:0]     fb_level, bvh_level;
  logic [15:0]       drop_count;

  mem_write_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .fb_w_valid(fb_w_valid), .fb_w_addr(fb_w_addr), .fb_w_data(fb_w_data),
    .fb_w_mask(fb_w_mask), .fb_w_ready(fb_w_ready),
    .bvh_w_valid(bvh_w_valid), .bvh_w_addr(bvh_w_addr), .bvh_w_data(bvh_w_data),
    .bvh_w_mask(bvh_w_mask), .bvh_w_ready(bvh_w_ready),
    .out_w_valid(out_w_valid), .out_w_addr(out_w_addr), .out_w_data(out_w_data),
    .out_w_mask(out_w_mask), .out_w_src(out_w_src), .out_w_ready(out_w_ready),
    .fb_level(fb_level), .bvh_level(bvh_level), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int   cmp_count = 0;
  int   err_count = 0;
  ent_t q_fb[$];
  ent_t q_bvh[$];
  bit   m_ov, m_src, m_rr;
  ent_t m_out;
  int   m_drop;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    cmp_count++;
    if (obs !== exp) begin
      err_count++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q_fb.delete();
    q_bvh.delete();
    m_ov = 0; m_src = 0; m_rr = 0; m_drop = 0; m_out = '0;
  endtask

  task automatic compare_all();
    check("out_valid", 128'(out_w_valid), 128'(m_ov));
    if (m_ov) begin
      check("out_addr", 128'(out_w_addr), 128'(m_out.addr));
      check("out_data", 128'(out_w_data), 128'(m_out.data));
      check("out_mask", 128'(out_w_mask), 128'(m_out.mask));
      check("out_src",  128'(out_w_src),  128'(m_src));
    end
    check("fb_level",    128'(fb_level),    128'(q_fb.size()));
    check("bvh_level",   128'(bvh_level),   128'(q_bvh.size()));
    check("fb_ready",    128'(fb_w_ready),  128'(q_fb.size() != DEPTH));
    check("bvh_ready",   128'(bvh_w_ready), 128'(q_bvh.size() != DEPTH));
    check("drop_count",  128'(drop_count),  128'(m_drop));
  endtask

  // Advance one clock: predict from the rules using the current inputs, then compare.
  task automatic step();
    bit   rf, rb, nf, nb, g;
    int   d;
    ent_t e;
    rf = (q_fb.size() != DEPTH);
    rb = (q_bvh.size() != DEPTH);
    d  = int'(fb_w_valid && !rf) + int'(bvh_w_valid && !rb);
    m_drop = (m_drop + d > 65535) ? 65535 : m_drop + d;
    if (!m_ov || out_w_ready) begin
      if (m_ov)
        $display("txn src=%0d addr=%07h mask=%04h data=%032h", m_src, m_out.addr, m_out.mask, m_out.data);
      nf = (q_fb.size() > 0);
      nb = (q_bvh.size() > 0);
      if (nf && nb) begin
        g = m_rr;
        m_rr = !m_rr;
      end else begin
        g = nb;
      end
      if (nf || nb) begin
        m_ov  = 1;
        m_src = g;
        if (g) m_out = q_bvh.pop_front();
        else   m_out = q_fb.pop_front();
      end else begin
        m_ov = 0;
      end
    end
    if (fb_w_valid && rf) begin
      e = {fb_w_addr, fb_w_data, fb_w_mask};
      q_fb.push_back(e);
    end
    if (bvh_w_valid && rb) begin
      e = {bvh_w_addr, bvh_w_data, bvh_w_mask};
      q_bvh.push_back(e);
    end
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic drive(input int pf, input int pb, input int pr);
    fb_w_valid  = ($urandom_range(99) < pf);
    bvh_w_valid = ($urandom_range(99) < pb);
    out_w_ready = ($urandom_range(99) < pr);
    fb_w_addr   = ADDR_W'($urandom);
    bvh_w_addr  = ADDR_W'($urandom);
    fb_w_data   = {$urandom, $urandom, $urandom, $urandom};
    bvh_w_data  = {$urandom, $urandom, $urandom, $urandom};
    fb_w_mask   = ($urandom_range(7) == 0) ? '0 : MASK_W'($urandom);
    bvh_w_mask  = ($urandom_range(7) == 0) ? '0 : MASK_W'($urandom);
  endtask

  task automatic run_random(input int cycles, input int pf, input int pb, input int pr);
    for (int i = 0; i < cycles; i++) begin
      drive(pf, pb, pr);
      step();
    end
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0);
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    #1 reset = 1'b0;

    // Three FB writes in a row with the controller always ready.
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 100);
      fb_w_valid = 1'b1;
      fb_w_addr  = ADDR_W'(32'h100 + 32'h10 * i);
      step();
    end
    run_random(4, 0, 0, 100);

    run_random(300, 50, 50, 70);

    // Stall while both sources stream, then drain: grants must alternate.
    run_random(20, 100, 100, 0);
    run_random(25, 0, 0, 100);

    // FB-only overflow under stall, then single-cycle ready pulses at full.
    run_random(12, 100, 0, 0);
    for (int i = 0; i < 4; i++) begin
      drive(100, 0, 100);
      step();
      drive(100, 0, 0);
      step();
    end
    run_random(20, 0, 0, 100);

    run_random(400, 60, 60, 40);

    // Asynchronous reset with entries queued and the output stage loaded.
    run_random(6, 100, 100, 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_out_valid", 128'(out_w_valid), 128'(0));
    check("rst_fb_level",  128'(fb_level),    128'(0));
    check("rst_bvh_level", 128'(bvh_level),   128'(0));
    check("rst_fb_ready",  128'(fb_w_ready),  128'(1));
    check("rst_bvh_ready", 128'(bvh_w_ready), 128'(1));
    check("rst_drop",      128'(drop_count),  128'(0));
    model_clear();
    drive(0, 0, 100);
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    run_random(10, 0, 0, 100);
    run_random(200, 50, 50, 60);

    // Drive the drop counter into saturation with both sources dropping each cycle.
    run_random(33000, 100, 100, 0);
    run_random(20, 100, 100, 30);
    run_random(30, 0, 0, 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
    $finish;
  end

endmodule
